word_deserializer: RTL
======================

# word_deserializer

Serial-to-parallel receiver for the arithmetic logic processor. It accepts one data bit per `bit_valid` strobe and assembles W bits into a word, LSB-first or MSB-first. It presents the completed word on a registered parallel output with a valid/ready handshake. It is the receiving end of the bit stream produced by the team's shift-register serializers.

## Interface
- `W`, default 4: word width in bits; legal range W >= 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is accepted on this edge.
- `lsb_first`  in  1  word order; 1 = LSB first (right shift), 0 = MSB first (left shift). Sampled only on the first bit of a word.
- `word_out`  out  W  assembled word; stable while `word_valid`=1.
- `word_valid`  out  1  `word_out` holds an undelivered word.
- `word_ready`  in  1  consumer takes the word on an edge where `word_valid`=1.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `busy`  out  1  a word is partially received.
- `parity_err`  out  1  only with `PARITY_EN`; qualifies `word_out`.

## Operation
- Reset values:
  - `word_out` = 0, `word_valid` = 0, `overrun` = 0, `busy` = 0, `parity_err` = 0.
  - Shift register and bit counter = 0; FSM in IDLE.
- FSM states:
  - **IDLE**: on `bit_valid`, latch `lsb_first` into `dir`, shift in the first bit, set count = 1, go to SHIFT.
  - **SHIFT**: on each `bit_valid`, shift and increment count. On acceptance of bit W: without the macro, complete the word and go to IDLE; with the macro, go to PARITY.
  - **PARITY** (macro only): the next `bit_valid` is the parity bit. Complete the word, then go to IDLE.
- Shift rule:
  - `dir`=1: `sh` = {bit_in, sh[W-1:1]}.
  - `dir`=0: `sh` = {sh[W-2:0], bit_in}.
- `lsb_first` changes mid-word are ignored.
- Word completion:
  - Load the holding register (`word_out`) if `word_valid`=0, or if `word_valid`=1 and `word_ready`=1 on the same edge. `word_valid` is 1 afterwards.
  - Otherwise drop the new word, keep the old `word_out`, and pulse `overrun` for exactly one cycle.
- Drain: on an edge with `word_valid`=1, `word_ready`=1 and no completion, clear `word_valid`. `word_out` retains its value.
- `busy` = 1 in SHIFT and PARITY, 0 in IDLE.
- `bit_valid`=0 cycles are gaps. They are unbounded; no timeout.
- Reset mid-word discards the partial word and any held word.
- Counter width is $clog2(W+1). Count never exceeds W.

## Timing
- Each `bit_valid` edge accepts exactly one bit; back-to-back bits every cycle are supported.
- `word_valid` rises the cycle after the edge that accepts the final bit: bit W, or the parity bit with the macro.
- Minimum word period:
  - W cycles without the macro, W+1 with it.
  - Sustained full rate requires `word_ready` within W cycles of `word_valid`.
- `overrun` is asserted the cycle after the dropping edge.
- `word_ready` while `word_valid`=0 has no effect.
- A new word may begin on the edge after completion; receiving continues while a word is held.

## Configuration
- `WORD_DESERIALIZER_PARITY_EN`:
  - When defined: the PARITY state and the `parity_err` port exist. Even parity: `parity_err` = XOR(data bits, parity bit). It loads with `word_out` and is cleared by reset only.
  - When undefined: no PARITY state, no `parity_err` port, and the word completes on bit W.

## Structure
- Package `word_deserializer_pkg`:
  - State enum {IDLE, SHIFT, PARITY}.
  - Even-parity polarity constant.
- Sub-module `deser_shift_core` holds the shift register, `dir` latch and bit counter. Outputs `sh` and `last_bit`.
- The top level owns the FSM, holding register, handshake and `overrun`.

## Test plan
- W=4, `lsb_first`=0, bits 1,0,1,1 on consecutive cycles, `word_ready`=0 -> `word_out`=4'b1011 with `word_valid`=1 one cycle after the 4th bit; `busy`=0.
- W=4, `lsb_first`=1, bits 1,0,1,1 -> `word_out`=4'b1101. Toggle `lsb_first` after the first bit -> result unchanged.
- Two words 4'b1011 then 4'b0110, `word_ready`=0 throughout -> `overrun` high for one cycle after the 2nd word, `word_out` stays 4'b1011.
- Second word completes on the same edge as `word_ready`=1 -> `word_out`=4'b0110, `word_valid` stays 1, no `overrun`.
- Reset after 2 bits, then bits 0,1,1,1 MSB-first -> `word_out`=4'b0111, no residue from the partial word.
- With `PARITY_EN`, W=4: bits 1,0,1,1 then parity 1 -> `parity_err`=0. Same data with parity 0 -> `parity_err`=1.

Source files
------------

// File: rtl/word_deserializer_pkg.sv
// rtl/word_deserializer_pkg.sv - shared types and constants for the word deserializer
package word_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // XORed into the data/parity reduction; 0 selects even parity.
  localparam logic EVEN_PARITY = 1'b0;

endpackage

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - shift register, direction latch and bit counter
module deser_shift_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         first,
  input  logic         lsb_first,
  input  logic         bit_in,
  output logic [W-1:0] sh,
  output logic [W-1:0] sh_next,
  output logic         last_bit
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  logic          dir;
  logic          dir_eff;
  logic [CW-1:0] count;
  logic [W-1:0]  base;

  // The first bit of a word uses the live lsb_first; later bits use the latched copy.
  assign dir_eff  = first ? lsb_first : dir;
  assign base     = first ? '0 : sh;
  assign sh_next  = dir_eff ? {bit_in, base[W-1:1]} : {base[W-2:0], bit_in};
  assign last_bit = (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      sh    <= '0;
      dir   <= 1'b0;
      count <= '0;
    end else if (shift_en) begin
      sh <= sh_next;
      if (first) begin
        dir   <= lsb_first;
        count <= CW'(1);
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_deserializer.sv
// rtl/word_deserializer.sv - serial-to-parallel receiver with valid/ready holding register
// Optional trailing even-parity bit when WORD_DESERIALIZER_PARITY_EN is defined.
module word_deserializer
  import word_deserializer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         lsb_first,
  output logic [W-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         overrun,
`ifdef WORD_DESERIALIZER_PARITY_EN
  output logic         busy,
  output logic         parity_err
`else
  output logic         busy
`endif
);

  state_t       state, next_state;
  logic         shift_en;
  logic         first;
  logic         complete;
  logic         last_bit;
  logic [W-1:0] sh;
  logic [W-1:0] sh_next;
  logic [W-1:0] word_d;

  deser_shift_core #(.W(W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .first    (first),
    .lsb_first(lsb_first),
    .bit_in   (bit_in),
    .sh       (sh),
    .sh_next  (sh_next),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    first      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid) begin
          shift_en   = 1'b1;
          first      = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef WORD_DESERIALIZER_PARITY_EN
            next_state = PARITY;
`else
            complete   = 1'b1;
            next_state = IDLE;
`endif
          end
        end
      end
`ifdef WORD_DESERIALIZER_PARITY_EN
      PARITY: begin
        if (bit_valid) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // In PARITY the data bits are already in sh; otherwise the final bit is still in flight.
  assign word_d = (state == PARITY) ? sh : sh_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!word_valid || word_ready) begin
          word_out   <= word_d;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef WORD_DESERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (complete && (!word_valid || word_ready)) begin
      parity_err <= (^sh) ^ bit_in ^ EVEN_PARITY;
    end
  end
`endif

endmodule
